// File: rtl/sram_stream_arbiter.sv
// Timed sequencer for an asynchronous 512K x 32 SRAM, shared round-robin between
// a streamed fill writer (consecutive addresses from 0) and a random-access reader.
module sram_stream_arbiter #(
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        start,
    input  logic [18:0] wr_len,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic        init_busy,
    output logic        init_done,
    input  logic        rd_req,
    input  logic [18:0] rd_addr,
    output logic        rd_gnt,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic [18:0] SRAM_ADDR,
    output logic [31:0] SRAM_DATA_OUT,
    output logic        SRAM_DATA_OE,
    input  logic [31:0] SRAM_DATA_IN,
    output logic        SRAM_CE_n,
    output logic        SRAM_WE_n,
    output logic        SRAM_OE_n
);

    localparam int MAX_CYCLES = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_ACCESS,
        RD_TURN
    } state_t;

    typedef enum logic {
        GRANT_WRITE,
        GRANT_READ
    } grant_t;

    state_t        state;
    grant_t        last_grant;
    logic [TW-1:0] timer;
    logic [18:0]   fill_addr;
    logic [18:0]   fill_last;
    logic          grant_en;
    logic          wr_cand;
    logic          pick_wr;

    // Grants are handshake strobes, so they are decoded from the registered state
    // in the same cycle the requester presents its data/address; held off in reset.
    assign grant_en = (state == IDLE) && RSTn;
    assign wr_cand  = init_busy && wr_valid;
    assign pick_wr  = wr_cand && (!rd_req || (last_grant == GRANT_READ));
    assign wr_ready = grant_en && pick_wr;
    assign rd_gnt   = grant_en && rd_req && !pick_wr;

    // NOTE: all state and pin registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order inside the block.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= IDLE;
            last_grant    <= GRANT_READ;
            timer         <= '0;
            fill_addr     <= '0;
            fill_last     <= '0;
            init_busy     <= 1'b0;
            init_done     <= 1'b0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            SRAM_ADDR     <= '0;
            SRAM_DATA_OUT <= '0;
            SRAM_DATA_OE  <= 1'b0;
            SRAM_CE_n     <= 1'b1;
            SRAM_WE_n     <= 1'b1;
            SRAM_OE_n     <= 1'b1;
        end else begin
            rd_valid <= 1'b0;

            if (start && !init_busy) begin
                fill_last <= wr_len;
                fill_addr <= '0;
                init_busy <= 1'b1;
                init_done <= 1'b0;
            end

            // Pin values are loaded on entry, so they are present for the whole state.
            case (state)
                IDLE: begin
                    if (wr_ready) begin
                        last_grant    <= GRANT_WRITE;
                        SRAM_ADDR     <= fill_addr;
                        SRAM_DATA_OUT <= wr_data;
                        SRAM_CE_n     <= 1'b0;
                        SRAM_DATA_OE  <= 1'b1;
                        state         <= WR_SETUP;
                    end else if (rd_gnt) begin
                        last_grant <= GRANT_READ;
                        SRAM_ADDR  <= rd_addr;
                        SRAM_CE_n  <= 1'b0;
                        SRAM_OE_n  <= 1'b0;
                        timer      <= TW'(RD_CYCLES - 1);
                        state      <= RD_ACCESS;
                    end
                end
                WR_SETUP: begin
                    SRAM_WE_n <= 1'b0;
                    timer     <= TW'(WE_CYCLES - 1);
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (timer == '0) begin
                        SRAM_WE_n <= 1'b1;
                        state     <= WR_HOLD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WR_HOLD: begin
                    SRAM_CE_n    <= 1'b1;
                    SRAM_DATA_OE <= 1'b0;
                    state        <= IDLE;
                    // The counter stops on the last address so a full fill never wraps to 0.
                    if (fill_addr == fill_last) begin
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        fill_addr <= fill_addr + 1'b1;
                    end
                end
                RD_ACCESS: begin
                    if (timer == '0) begin
                        rd_data   <= SRAM_DATA_IN;
                        rd_valid  <= 1'b1;
                        SRAM_CE_n <= 1'b1;
                        SRAM_OE_n <= 1'b1;
                        state     <= RD_TURN;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RD_TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_arbiter.sv
// Bench for sram_stream_arbiter: behavioural SRAM, fill source and read source, with a
// reference model of the expected fill sequence, read results and grant order.
module tb_sram_stream_arbiter;

    localparam int WE_CYCLES = 2;
    localparam int RD_CYCLES = 2;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        start = 1'b0;
    logic [18:0] wr_len = '0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready, init_busy, init_done;
    logic        rd_req = 1'b0;
    logic [18:0] rd_addr = '0;
    logic        rd_gnt, rd_valid;
    logic [31:0] rd_data;
    logic [18:0] SRAM_ADDR;
    logic [31:0] SRAM_DATA_OUT;
    logic        SRAM_DATA_OE;
    logic [31:0] SRAM_DATA_IN = '0;
    logic        SRAM_CE_n, SRAM_WE_n, SRAM_OE_n;

    always #5 CLK = ~CLK;

    sram_stream_arbiter #(.WE_CYCLES(WE_CYCLES), .RD_CYCLES(RD_CYCLES)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .wr_len(wr_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .init_busy(init_busy), .init_done(init_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DATA_OUT(SRAM_DATA_OUT), .SRAM_DATA_OE(SRAM_DATA_OE),
        .SRAM_DATA_IN(SRAM_DATA_IN), .SRAM_CE_n(SRAM_CE_n), .SRAM_WE_n(SRAM_WE_n),
        .SRAM_OE_n(SRAM_OE_n)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] src_base, src_step;
    int          src_idx;
    logic        src_rand = 1'b0;
    logic        rd_rand = 1'b0;

    logic [18:0] rd_q[$];
    logic [31:0] exp_rd_q[$];
    int          gnt_cyc_q[$];
    int          wr_gnt_cyc[$];
    byte         grant_log[$];
    logic [18:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    logic [18:0] oe_addr[$];
    int          we_width[$];
    int          oe_width[$];
    int          we_run, oe_run, viol, rd_seen, rd_pushed, done_cyc;
    logic        prev_done;
    logic [31:0] sram_mem [logic [18:0]];

    function automatic logic [31:0] src_word(input int i);
        return src_base + 32'(i) * src_step;
    endfunction

    function automatic logic [31:0] pattern(input logic [18:0] a);
        return {13'h1A5, a};
    endfunction

    function automatic logic [31:0] mem_read(input logic [18:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return pattern(a);
    endfunction

    task automatic push_read(input logic [18:0] a, input logic [31:0] exp);
        rd_q.push_back(a);
        exp_rd_q.push_back(exp);
        rd_pushed++;
        rd_req  = 1'b1;
        rd_addr = rd_q[0];
    endtask

    task automatic set_source(input logic [31:0] base, input logic [31:0] step);
        src_base = base;
        src_step = step;
        src_idx  = 0;
        wr_data  = src_word(0);
    endtask

    // One clock: observe at the falling edge, then update stimulus just after the rising edge.
    task automatic tick();
        logic        took_wr, took_rd;
        logic [31:0] exp;
        int          g;
        @(negedge CLK);
        cyc++;
        if (!SRAM_WE_n && !SRAM_OE_n) viol++;
        if (SRAM_DATA_OE && (SRAM_CE_n || !SRAM_OE_n)) viol++;
        if (!SRAM_CE_n && !SRAM_WE_n) begin
            if (we_run == 0) begin
                wlog_addr.push_back(SRAM_ADDR);
                wlog_data.push_back(SRAM_DATA_OUT);
                sram_mem[SRAM_ADDR] = SRAM_DATA_OUT;
            end
            we_run++;
        end else if (we_run != 0) begin
            we_width.push_back(we_run);
            we_run = 0;
        end
        if (!SRAM_CE_n && !SRAM_OE_n) begin
            if (oe_run == 0) oe_addr.push_back(SRAM_ADDR);
            oe_run++;
        end else if (oe_run != 0) begin
            oe_width.push_back(oe_run);
            oe_run = 0;
        end
        took_wr = wr_ready;
        took_rd = rd_gnt;
        if (wr_ready) begin
            grant_log.push_back("W");
            wr_gnt_cyc.push_back(cyc);
        end
        if (rd_gnt) begin
            grant_log.push_back("R");
            gnt_cyc_q.push_back(cyc);
        end
        if (rd_valid) begin
            rd_seen++;
            if (exp_rd_q.size() == 0 || gnt_cyc_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 at cycle %0d, required no pending read", cyc);
            end else begin
                exp = exp_rd_q.pop_front();
                g   = gnt_cyc_q.pop_front();
                n_cmp++;
                if (rd_data !== exp) begin
                    n_err++;
                    $display("FAIL rd_data: got %08h required %08h", rd_data, exp);
                end
                n_cmp++;
                if ((cyc - g) !== RD_CYCLES + 1) begin
                    n_err++;
                    $display("FAIL rd_latency: got %0d required %0d", cyc - g, RD_CYCLES + 1);
                end
            end
        end
        if (init_done && !prev_done) done_cyc = cyc;
        prev_done = init_done;

        @(posedge CLK);
        #1;
        if (took_wr) begin
            src_idx++;
            wr_data = src_word(src_idx);
        end
        if (took_rd && rd_q.size() != 0) void'(rd_q.pop_front());
        if (src_rand) wr_valid = ($urandom_range(0, 3) != 0);
        if (rd_rand && rd_q.size() < 2 && $urandom_range(0, 4) == 0) begin
            logic [18:0] ra;
            ra = {1'b1, 18'($urandom)};
            push_read(ra, pattern(ra));
        end
        rd_req  = (rd_q.size() != 0);
        rd_addr = rd_req ? rd_q[0] : '0;
        SRAM_DATA_IN = (!SRAM_CE_n && !SRAM_OE_n) ? mem_read(SRAM_ADDR) : 32'h0;
    endtask

    task automatic clear_logs();
        rd_q.delete(); exp_rd_q.delete(); gnt_cyc_q.delete(); wr_gnt_cyc.delete();
        grant_log.delete(); wlog_addr.delete(); wlog_data.delete(); oe_addr.delete();
        we_width.delete(); oe_width.delete(); sram_mem.delete();
        we_run = 0; oe_run = 0; rd_seen = 0; rd_pushed = 0; done_cyc = -1; prev_done = 1'b0;
    endtask

    task automatic do_reset();
        RSTn = 1'b0; start = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; rd_addr = '0;
        src_rand = 1'b0; rd_rand = 1'b0;
        clear_logs();
        tick();
        tick();
        clear_logs();
        RSTn = 1'b1;
    endtask

    task automatic pulse_start(input logic [18:0] len);
        start  = 1'b1;
        wr_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int k = 0; k < limit && !init_done; k++) tick();
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_err++;
            $display("FAIL fill_done_timeout: got init_done=%b required 1 within %0d cycles", init_done, limit);
        end
    endtask

    task automatic check_fill(input string name, input int words);
        n_cmp++;
        if (wlog_addr.size() !== words) begin
            n_err++;
            $display("FAIL %s_count: got %0d writes required %0d", name, wlog_addr.size(), words);
        end
        for (int i = 0; i < words && i < wlog_addr.size(); i++) begin
            n_cmp++;
            if (wlog_addr[i] !== 19'(i) || wlog_data[i] !== src_word(i)) begin
                n_err++;
                $display("FAIL %s_word%0d: got addr %05h data %08h required addr %05h data %08h",
                         name, i, wlog_addr[i], wlog_data[i], 19'(i), src_word(i));
            end
        end
    endtask

    task automatic check_pins_reset(input string name);
        n_cmp++;
        if ({SRAM_CE_n, SRAM_WE_n, SRAM_OE_n, SRAM_DATA_OE} !== 4'b1110) begin
            n_err++;
            $display("FAIL %s_pins: got ce/we/oe/doe=%b%b%b%b required 1110",
                     name, SRAM_CE_n, SRAM_WE_n, SRAM_OE_n, SRAM_DATA_OE);
        end
        n_cmp++;
        if ({init_busy, init_done, wr_ready, rd_gnt, rd_valid} !== 5'b0) begin
            n_err++;
            $display("FAIL %s_status: got busy/done/wrdy/gnt/vld=%b%b%b%b%b required 00000",
                     name, init_busy, init_done, wr_ready, rd_gnt, rd_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_pins_reset("reset_initial");
        n_cmp++;
        if (SRAM_ADDR !== 19'h0 || SRAM_DATA_OUT !== 32'h0 || rd_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_regs: got addr %05h dout %08h rd_data %08h required all 0",
                     SRAM_ADDR, SRAM_DATA_OUT, rd_data);
        end
        // Reset in the middle of a read, while OE_n is low.
        push_read(19'h00777, pattern(19'h00777));
        tick();
        tick();
        n_cmp++;
        if (SRAM_OE_n !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pre_read: got OE_n=%b required 0", SRAM_OE_n);
        end
        #2 RSTn = 1'b0;
        #1 check_pins_reset("reset_async_read");
        do_reset();
        repeat (3) tick();
        n_cmp++;
        if (SRAM_CE_n !== 1'b1 || grant_log.size() !== 0) begin
            n_err++;
            $display("FAIL reset_idle: got CE_n=%b grants=%0d required 1 and 0", SRAM_CE_n, grant_log.size());
        end
    endtask

    task automatic test_fill();
        do_reset();
        set_source(32'h000000A0, 32'h1);
        wr_valid = 1'b1;
        pulse_start(19'd3);
        wait_done(100);
        repeat (10) tick();
        wr_valid = 1'b0;
        check_fill("fill", 4);
        for (int i = 0; i < we_width.size(); i++) begin
            n_cmp++;
            if (we_width[i] !== WE_CYCLES) begin
                n_err++;
                $display("FAIL fill_we_width%0d: got %0d required %0d", i, we_width[i], WE_CYCLES);
            end
        end
        for (int i = 1; i < wr_gnt_cyc.size(); i++) begin
            n_cmp++;
            if (wr_gnt_cyc[i] - wr_gnt_cyc[i-1] !== WE_CYCLES + 3) begin
                n_err++;
                $display("FAIL fill_ready_spacing%0d: got %0d required %0d",
                         i, wr_gnt_cyc[i] - wr_gnt_cyc[i-1], WE_CYCLES + 3);
            end
        end
        n_cmp++;
        if (wr_gnt_cyc.size() !== 4 || done_cyc - wr_gnt_cyc[wr_gnt_cyc.size()-1] !== WE_CYCLES + 3) begin
            n_err++;
            $display("FAIL fill_done_timing: got %0d grants, done %0d cycles after last, required 4 and %0d",
                     wr_gnt_cyc.size(), done_cyc - wr_gnt_cyc[wr_gnt_cyc.size()-1], WE_CYCLES + 3);
        end
        n_cmp++;
        if (init_busy !== 1'b0 || init_done !== 1'b1) begin
            n_err++;
            $display("FAIL fill_status: got busy=%b done=%b required 0 1", init_busy, init_done);
        end
    endtask

    task automatic test_read();
        do_reset();
        sram_mem[19'h00012] = 32'hDEADBEEF;
        push_read(19'h00012, 32'hDEADBEEF);
        for (int k = 0; k < 20 && rd_seen == 0; k++) tick();
        repeat (3) tick();
        n_cmp++;
        if (rd_seen !== 1) begin
            n_err++;
            $display("FAIL read_count: got %0d rd_valid pulses required 1", rd_seen);
        end
        n_cmp++;
        if (oe_width.size() !== 1 || oe_width[0] !== RD_CYCLES || oe_addr[0] !== 19'h00012) begin
            n_err++;
            $display("FAIL read_oe: got %0d pulses width %0d addr %05h required 1, %0d, 00012",
                     oe_width.size(), oe_width[0], oe_addr[0], RD_CYCLES);
        end
        n_cmp++;
        if (wlog_addr.size() !== 0) begin
            n_err++;
            $display("FAIL read_no_write: got %0d WE_n pulses required 0", wlog_addr.size());
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] v;
        string       order;
        order = "WRWRWRWR";
        do_reset();
        set_source($urandom, $urandom | 32'h1);
        wr_valid = 1'b1;
        pulse_start(19'd3);
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            sram_mem[19'h00100 + 19'(i)] = v;
            push_read(19'h00100 + 19'(i), v);
        end
        for (int k = 0; k < 200 && !(init_done && rd_seen == 4); k++) tick();
        wr_valid = 1'b0;
        check_fill("arb_fill", 4);
        n_cmp++;
        if (rd_seen !== 4) begin
            n_err++;
            $display("FAIL arb_reads: got %0d required 4", rd_seen);
        end
        n_cmp++;
        if (grant_log.size() !== 8) begin
            n_err++;
            $display("FAIL arb_grant_count: got %0d required 8", grant_log.size());
        end
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            n_cmp++;
            if (grant_log[i] !== order[i]) begin
                n_err++;
                $display("FAIL arb_order%0d: got %c required %c", i, grant_log[i], order[i]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        set_source(32'h11110000, 32'h1);
        wr_valid = 1'b1;
        pulse_start(19'd6);
        for (int k = 0; k < 20 && we_run == 0; k++) tick();
        n_cmp++;
        if (SRAM_WE_n !== 1'b0) begin
            n_err++;
            $display("FAIL midwr_pre: got WE_n=%b required 0", SRAM_WE_n);
        end
        #2 RSTn = 1'b0;
        #1 check_pins_reset("midwr_async");
        do_reset();
        set_source(32'h22220000, 32'h3);
        wr_valid = 1'b1;
        pulse_start(19'd2);
        wait_done(100);
        wr_valid = 1'b0;
        repeat (3) tick();
        check_fill("midwr_refill", 3);
    endtask

    task automatic test_start_ignored();
        do_reset();
        set_source(32'h5A000000, 32'h101);
        wr_valid = 1'b1;
        pulse_start(19'd5);
        repeat (7) tick();
        pulse_start(19'd1);
        wait_done(200);
        repeat (30) tick();
        check_fill("restart_ignored", 6);
        n_cmp++;
        if (grant_log.size() !== 6) begin
            n_err++;
            $display("FAIL inactive_fill_ack: got %0d wr_ready pulses required 6", grant_log.size());
        end
        // Full-range fill: check the start and the sequential addressing; it never completes here.
        clear_logs();
        set_source(32'h0BAD0000, 32'h7);
        pulse_start(19'h7FFFF);
        for (int k = 0; k < 200 && wlog_addr.size() < 12; k++) tick();
        wr_valid = 1'b0;
        repeat (8) tick();
        check_fill("full_fill_head", 12);
        n_cmp++;
        if (init_busy !== 1'b1 || init_done !== 1'b0) begin
            n_err++;
            $display("FAIL full_fill_status: got busy=%b done=%b required 1 0", init_busy, init_done);
        end
    endtask

    task automatic test_random();
        int len;
        do_reset();
        set_source($urandom, $urandom | 32'h1);
        len = $urandom_range(8, 24);
        src_rand = 1'b1;
        rd_rand  = 1'b1;
        pulse_start(19'(len));
        for (int k = 0; k < 3000 && !init_done; k++) tick();
        rd_rand = 1'b0;
        src_rand = 1'b0;
        wr_valid = 1'b0;
        for (int k = 0; k < 100 && exp_rd_q.size() != 0; k++) tick();
        repeat (5) tick();
        check_fill("random_fill", len + 1);
        n_cmp++;
        if (rd_seen !== rd_pushed || rd_pushed == 0) begin
            n_err++;
            $display("FAIL random_reads: got %0d completions required %0d (nonzero)", rd_seen, rd_pushed);
        end
    endtask

    initial begin
        viol = 0;
        test_reset();
        test_fill();
        test_read();
        test_arbitration();
        test_reset_mid_write();
        test_start_ignored();
        test_random();
        n_cmp++;
        if (viol !== 0) begin
            n_err++;
            $display("FAIL pin_invariants: got %0d violating cycles required 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
